// File: rtl/uart_pkg.sv
// Shared state encodings, line constants and parity helper for the UART TX path.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

    // Payload is zero-extended to 9 bits, so the extra zeros do not change the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input logic typ);
        return (^data) ^ (typ == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit tick counter; bit_done marks the final clk cycle of the current serial bit.
module uart_tx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign bit_done = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear || bit_done) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit controller: frame sequencing, LSB-first serialiser, parity and stop bits.
module uart_tx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    output logic                  data_ack,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop2,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    logic [2:0]            state_q, state_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q, par_typ_q, stop2_q;
    logic                  tx_q, tx_d, busy_q, busy_d;
    logic                  accept, bit_done, timer_clear;

    uart_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .bit_done(bit_done)
    );

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        accept     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                accept = data_valid;
            end
            ST_START: begin
                bit_idx_d = '0;
                if (bit_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == LAST_IDX) begin
                        bit_idx_d = '0;
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        // Final stop cycle: hand off straight to the next frame if one waits.
                        stop_cnt_d = 1'b0;
                        accept     = data_valid;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                bit_idx_d  = '0;
                stop_cnt_d = 1'b0;
            end
        endcase
        if (accept) state_d = ST_START;
    end

    // Outputs are registered, decoded from the state being entered.
    always_comb begin
        tx_d   = LINE_IDLE;
        busy_d = 1'b0;
        case (state_d)
            ST_START:  begin tx_d = 1'b0;                              busy_d = 1'b1; end
            ST_DATA:   begin tx_d = data_q[bit_idx_d];                 busy_d = 1'b1; end
            ST_PARITY: begin tx_d = parity_bit(9'(data_q), par_typ_q); busy_d = 1'b1; end
            ST_STOP:   begin tx_d = LINE_IDLE;                         busy_d = 1'b1; end
            default:   begin tx_d = LINE_IDLE;                         busy_d = 1'b0; end
        endcase
    end

    assign timer_clear = (state_d != state_q) || (state_q == ST_IDLE);
    assign data_ack    = accept && !rst;
    assign tx_out      = tx_q;
    assign busy        = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= LINE_IDLE;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            if (accept) begin
                data_q    <= p_data;
                par_en_q  <= par_en;
                par_typ_q <= par_typ;
                stop2_q   <= stop2;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed bench: three DUT configurations, table-driven frames plus handoff and reset sequences.
module tb_uart_tx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] pd;
    logic [2:0] dv;
    logic       pe, pt, s2;
    logic       tx_a, tx_b, tx_c, busy_a, busy_b, busy_c, ack_a, ack_b, ack_c;
    logic       obs_tx, obs_busy, obs_ack;
    int         sel;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    uart_tx_frame_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut_a (
        .clk(clk), .rst(rst), .p_data(pd[7:0]), .data_valid(dv[0]), .data_ack(ack_a),
        .par_en(pe), .par_typ(pt), .stop2(s2), .tx_out(tx_a), .busy(busy_a)
    );
    uart_tx_frame_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut_b (
        .clk(clk), .rst(rst), .p_data(pd[7:0]), .data_valid(dv[1]), .data_ack(ack_b),
        .par_en(pe), .par_typ(pt), .stop2(s2), .tx_out(tx_b), .busy(busy_b)
    );
    uart_tx_frame_ctrl #(.DATA_WIDTH(5), .CLKS_PER_BIT(1)) dut_c (
        .clk(clk), .rst(rst), .p_data(pd[4:0]), .data_valid(dv[2]), .data_ack(ack_c),
        .par_en(pe), .par_typ(pt), .stop2(s2), .tx_out(tx_c), .busy(busy_c)
    );

    always_comb begin
        obs_tx   = tx_a;
        obs_busy = busy_a;
        obs_ack  = ack_a;
        if (sel == 1) begin
            obs_tx = tx_b; obs_busy = busy_b; obs_ack = ack_b;
        end else if (sel == 2) begin
            obs_tx = tx_c; obs_busy = busy_c; obs_ack = ack_c;
        end
    end

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       pe;
        logic       pt;
        logic       s2;
        logic [15:0] exp;  // line bits in time order, read from bit len-1 down to 0
        int         len;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Entered and left just after a posedge with the selected DUT idle.
    task automatic run_frame(input vec_t v);
        int cpb;
        cpb = (v.inst == 1) ? 4 : 1;
        sel = v.inst;
        pd  = v.data;
        pe  = v.pe;
        pt  = v.pt;
        s2  = v.s2;
        dv[v.inst] = 1'b1;
        @(negedge clk);
        check("accept_ack", obs_ack, 1'b1);
        check("accept_busy", obs_busy, 1'b0);
        @(posedge clk);
        #1 dv[v.inst] = 1'b0;
        pd = ~v.data;  // mid-frame input changes must not matter
        pt = ~v.pt;
        for (int i = 0; i < v.len; i++) begin
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                check("frame_tx", obs_tx, v.exp[v.len-1-i]);
                check("frame_busy", obs_busy, 1'b1);
                check("frame_no_ack", obs_ack, 1'b0);
            end
        end
        @(negedge clk);
        check("post_tx", obs_tx, 1'b1);
        check("post_busy", obs_busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] f1, f2;
        tbl[0] = '{0, 9'h0A5, 1'b0, 1'b0, 1'b0, 16'b0101001011,     10};
        tbl[1] = '{0, 9'h0A5, 1'b1, 1'b0, 1'b0, 16'b01010010101,    11};
        tbl[2] = '{0, 9'h0A5, 1'b1, 1'b1, 1'b0, 16'b01010010111,    11};
        tbl[3] = '{0, 9'h000, 1'b0, 1'b0, 1'b1, 16'b00000000011,    11};
        tbl[4] = '{0, 9'h0FF, 1'b1, 1'b0, 1'b0, 16'b01111111101,    11};
        tbl[5] = '{0, 9'h080, 1'b1, 1'b1, 1'b1, 16'b000000001011,   12};
        tbl[6] = '{1, 9'h001, 1'b0, 1'b0, 1'b1, 16'b01000000011,    11};
        tbl[7] = '{2, 9'h016, 1'b1, 1'b1, 1'b0, 16'b00110101,       8};

        sel = 0; rst = 1'b1; dv = '0; pd = '0; pe = 0; pt = 0; s2 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1;
            check("reset_tx", obs_tx, 1'b1);
            check("reset_busy", obs_busy, 1'b0);
            check("reset_ack", obs_ack, 1'b0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_frame(tbl[i]);

        // Back-to-back handoff: 8'h55 then 8'h0F with data_valid held.
        sel = 0; pe = 0; pt = 0; s2 = 0;
        f1 = 10'b0101010101;
        f2 = 10'b0111100001;
        pd = 9'h055; dv[0] = 1'b1;
        @(negedge clk);
        check("b2b_ack0", obs_ack, 1'b1);
        @(posedge clk);
        #1 pd = 9'h00F;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("b2b_tx", obs_tx, (i < 10) ? f1[9-i] : f2[19-i]);
            check("b2b_busy", obs_busy, 1'b1);
            check("b2b_ack", obs_ack, (i == 9));
            @(posedge clk);
            #1 if (i == 9) dv[0] = 1'b0;
        end
        @(negedge clk);
        check("b2b_idle_busy", obs_busy, 1'b0);
        @(posedge clk);
        #1;

        // Reset during data bit 3, then a normal frame.
        pd = 9'h0A5; dv[0] = 1'b1;
        @(posedge clk);
        #1 dv[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check("bit3_tx", obs_tx, 1'b0);
        check("bit3_busy", obs_busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_tx", obs_tx, 1'b1);
        check("abort_busy", obs_busy, 1'b0);
        check("abort_state", (dut_a.state_q == 3'd0), 1'b1);
        @(posedge clk);
        #1;
        run_frame(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
